// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front end.
package vend_pkg;

  typedef enum logic [1:0] {IDLE, CREDIT, BOUGHT, SETTLE} state_e;

  // Coin weights in half-yuan units.
  localparam int W_HALF = 1;
  localparam int W_ONE  = 2;
  localparam int W_TEN  = 20;

  // Default product prices in half-yuan units.
  localparam int PRICE_ONE_DEF = 5;
  localparam int PRICE_TWO_DEF = 10;

  // Level-input lane map for the edge detector array.
  localparam int NUM_IN    = 7;
  localparam int EV_HALF   = 0;
  localparam int EV_ONE    = 1;
  localparam int EV_TEN    = 2;
  localparam int EV_SEL1   = 3;
  localparam int EV_SEL2   = 4;
  localparam int EV_CANCEL = 5;
  localparam int EV_CHANGE = 6;

endpackage

// File: rtl/edge_pulse.sv
// Rising-edge detector for one level input. With COIN_SYNC_EN defined the
// input first passes a 2-flop synchronizer (adds 2 cycles of latency).
module edge_pulse (
  input  logic clk,
  input  logic reset,
  input  logic lvl_i,
  output logic pulse_o
);

  logic lvl_s;

`ifdef COIN_SYNC_EN
  logic [1:0] sync_q;

  // Two-flop synchronizer for asynchronous sensor levels.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], lvl_i};
  end

  assign lvl_s = sync_q[1];
`else
  assign lvl_s = lvl_i;
`endif

  logic cur_q, prev_q;

  // Sample the level and keep one edge of history; history updates every
  // cycle so a level held through SETTLE never re-fires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      cur_q  <= lvl_s;
      prev_q <= cur_q;
    end
  end

  assign pulse_o = cur_q & ~prev_q;

endmodule

// File: rtl/coin_ledger.sv
// Credit keeper: edge-detects coin/button levels, tracks credit in half-yuan
// units and flags purchases, cancels and denials for the vending FSM.
// Optional macro COIN_SYNC_EN adds input synchronizers (see edge_pulse).
module coin_ledger
  import vend_pkg::*;
#(
  parameter int VAL_W      = 10,
  parameter int PRICE_ONE  = PRICE_ONE_DEF,
  parameter int PRICE_TWO  = PRICE_TWO_DEF,
  parameter int CREDIT_MAX = 1000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coin_half,
  input  logic             coin_one,
  input  logic             coin_ten,
  input  logic             sel_one,
  input  logic             sel_two,
  input  logic             cancel_btn,
  input  logic             change_done,
  output logic [VAL_W-1:0] coin_val,
  output logic             buy_flag,
  output logic             cancel_flag,
  output logic             vend_one,
  output logic             vend_two,
  output logic             deny
);

  localparam logic [VAL_W:0] WH   = (VAL_W+1)'(W_HALF);
  localparam logic [VAL_W:0] WO   = (VAL_W+1)'(W_ONE);
  localparam logic [VAL_W:0] WT   = (VAL_W+1)'(W_TEN);
  localparam logic [VAL_W:0] P1   = (VAL_W+1)'(PRICE_ONE);
  localparam logic [VAL_W:0] P2   = (VAL_W+1)'(PRICE_TWO);
  localparam logic [VAL_W:0] MAXV = (VAL_W+1)'(CREDIT_MAX);

  logic [NUM_IN-1:0] lvl, ev;

  assign lvl = {change_done, cancel_btn, sel_two, sel_one, coin_ten, coin_one, coin_half};

  for (genvar i = 0; i < NUM_IN; i++) begin : g_ep
    edge_pulse u_ep (.clk(clk), .reset(reset), .lvl_i(lvl[i]), .pulse_o(ev[i]));
  end

  state_e           state_q, state_d;
  logic [VAL_W-1:0] credit_q, credit_d;
  logic             buy_q, buy_d;
  logic             cancel_q, cancel_d, v1_q, v1_d, v2_q, v2_d, deny_q, deny_d;

  logic [VAL_W:0] sum, tot, c, price, rem;
  logic           sel_any;

  // Next-state: cancel > change_done > coins > select; SETTLE ignores events.
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    buy_d    = buy_q;
    cancel_d = 1'b0;
    v1_d     = 1'b0;
    v2_d     = 1'b0;
    deny_d   = 1'b0;
    sum      = (ev[EV_HALF] ? WH : '0) + (ev[EV_ONE] ? WO : '0) + (ev[EV_TEN] ? WT : '0);
    tot      = {1'b0, credit_q} + sum;
    c        = tot;
    sel_any  = ev[EV_SEL1] | ev[EV_SEL2];
    price    = ev[EV_SEL1] ? P1 : P2;   // sel_one wins a simultaneous press
    rem      = c - price;
    if (state_q == SETTLE) begin
      state_d  = IDLE;
      credit_d = '0;
      buy_d    = 1'b0;
    end else if (ev[EV_CANCEL] && state_q != IDLE) begin
      cancel_d = 1'b1;
      state_d  = SETTLE;
      credit_d = '0;
      buy_d    = 1'b0;
    end else if (ev[EV_CHANGE] && state_q == BOUGHT) begin
      state_d  = SETTLE;
      credit_d = '0;
      buy_d    = 1'b0;
    end else begin
      // Whole-cycle coin refusal when the ceiling would be exceeded.
      if (tot > MAXV) begin
        c      = {1'b0, credit_q};
        deny_d = 1'b1;
      end
      rem      = c - price;
      credit_d = c[VAL_W-1:0];
      if (sel_any) begin
        if (c >= price) begin
          credit_d = rem[VAL_W-1:0];
          v1_d     = ev[EV_SEL1];
          v2_d     = ~ev[EV_SEL1];
          buy_d    = 1'b1;
          state_d  = BOUGHT;
        end else begin
          deny_d = 1'b1;
        end
      end
      if (state_d == IDLE && c != '0) state_d = CREDIT;
    end
  end

  // State, credit and registered output pulses.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      credit_q <= '0;
      buy_q    <= 1'b0;
      cancel_q <= 1'b0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      deny_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      buy_q    <= buy_d;
      cancel_q <= cancel_d;
      v1_q     <= v1_d;
      v2_q     <= v2_d;
      deny_q   <= deny_d;
    end
  end

  assign coin_val    = credit_q;
  assign buy_flag    = buy_q;
  assign cancel_flag = cancel_q;
  assign vend_one    = v1_q;
  assign vend_two    = v2_q;
  assign deny        = deny_q;

endmodule

// File: tb/tb_coin_ledger.sv
// Directed table-driven bench for coin_ledger (default build, 1-cycle latency).
module tb_coin_ledger;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] lv;  // {change, cancel, sel2, sel1, ten, one, half}
  logic [9:0] coin_val;
  logic       buy_flag, cancel_flag, vend_one, vend_two, deny;

  always #5 clk = ~clk;

  coin_ledger dut (
    .clk(clk), .reset(reset),
    .coin_half(lv[0]), .coin_one(lv[1]), .coin_ten(lv[2]),
    .sel_one(lv[3]), .sel_two(lv[4]), .cancel_btn(lv[5]), .change_done(lv[6]),
    .coin_val(coin_val), .buy_flag(buy_flag), .cancel_flag(cancel_flag),
    .vend_one(vend_one), .vend_two(vend_two), .deny(deny)
  );

  localparam logic [6:0] HALF = 7'h01, ONE = 7'h02, TEN = 7'h04, S1 = 7'h08,
                         S2 = 7'h10, CAN = 7'h20, CHG = 7'h40, NONE = 7'h00;

  typedef struct {
    logic [6:0] in;
    logic [9:0] val;
    logic       buy, canc, v1, v2, dn;
  } vec_t;

  vec_t tbl[$];
  int   n_chk = 0, n_fail = 0;

  function automatic vec_t mk(logic [6:0] in, int val, bit buy, bit canc, bit v1, bit v2, bit dn);
    vec_t v;
    v.in = in; v.val = 10'(val); v.buy = buy; v.canc = canc; v.v1 = v1; v.v2 = v2; v.dn = dn;
    return v;
  endfunction

  task automatic chk(string nm, int val, bit buy, bit canc, bit v1, bit v2, bit dn);
    logic [14:0] act, exp;
    act = {coin_val, buy_flag, cancel_flag, vend_one, vend_two, deny};
    exp = {10'(val), buy, canc, v1, v2, dn};
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got val=%0d buy=%b canc=%b v1=%b v2=%b deny=%b, want val=%0d buy=%b canc=%b v1=%b v2=%b deny=%b",
               nm, coin_val, buy_flag, cancel_flag, vend_one, vend_two, deny,
               val, buy, canc, v1, v2, dn);
    end
  endtask

  // One input event: level high for one sample edge, then low; outputs are
  // sampled just after the following edge, where the event lands.
  task automatic step(input logic [6:0] in);
    @(negedge clk); lv = in;
    @(negedge clk); lv = NONE;
    @(posedge clk); #1;
  endtask

  initial begin
    tbl.push_back(mk(ONE,     2,   0, 0, 0, 0, 0));
    tbl.push_back(mk(ONE,     4,   0, 0, 0, 0, 0));
    tbl.push_back(mk(ONE,     6,   0, 0, 0, 0, 0));
    tbl.push_back(mk(TEN,     26,  0, 0, 0, 0, 0));
    tbl.push_back(mk(S2,      16,  1, 0, 0, 1, 0));
    tbl.push_back(mk(S1,      11,  1, 0, 1, 0, 0));
    tbl.push_back(mk(S2,      1,   1, 0, 0, 1, 0));
    tbl.push_back(mk(CHG,     0,   0, 0, 0, 0, 0));
    tbl.push_back(mk(S1,      0,   0, 0, 0, 0, 1));  // select in IDLE, zero credit
    tbl.push_back(mk(ONE,     2,   0, 0, 0, 0, 0));
    tbl.push_back(mk(ONE,     4,   0, 0, 0, 0, 0));
    tbl.push_back(mk(S1,      4,   0, 0, 0, 0, 1));
    tbl.push_back(mk(CAN,     0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(CAN,     0,   0, 0, 0, 0, 0));  // cancel in IDLE ignored
    tbl.push_back(mk(HALF|ONE, 3,  0, 0, 0, 0, 0));
    tbl.push_back(mk(CAN,     0,   0, 1, 0, 0, 0));
    tbl.push_back(mk(TEN,     20,  0, 0, 0, 0, 0));
    tbl.push_back(mk(S1|S2,   15,  1, 0, 1, 0, 0));

    lv = NONE;
    reset = 1'b1;
    #12;
    chk("reset_state", 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;

    foreach (tbl[i]) begin
      step(tbl[i].in);
      chk($sformatf("vec%0d", i), tbl[i].val, tbl[i].buy, tbl[i].canc, tbl[i].v1, tbl[i].v2, tbl[i].dn);
    end

    // change_done then a coin edge landing in SETTLE: the coin is discarded.
    @(negedge clk); lv = CHG;
    @(negedge clk); lv = ONE;
    @(negedge clk); lv = NONE;
    repeat (3) @(posedge clk); #1;
    chk("settle_discard", 0, 0, 0, 0, 0, 0);

    // Build 995: 49 notes, 7 one-yuan, 1 half.
    for (int k = 0; k < 49; k++) step(TEN);
    for (int k = 0; k < 7; k++) step(ONE);
    step(HALF);
    chk("credit_995", 995, 0, 0, 0, 0, 0);
    step(TEN | S1);
    chk("ceil_refuse_sel", 990, 1, 0, 1, 0, 1);
    step(TEN);
    chk("ceil_refuse_ten", 990, 1, 0, 0, 0, 1);
    for (int k = 0; k < 5; k++) step(ONE);
    chk("ceil_exact", 1000, 1, 0, 0, 0, 0);
    step(HALF);
    chk("ceil_refuse_half", 1000, 1, 0, 0, 0, 1);
    step(CAN);
    chk("cancel_bought", 0, 0, 1, 0, 0, 0);
    step(NONE);

    // Async reset mid-cycle with credit 20, cancel held across release.
    step(TEN);
    chk("pre_reset_20", 20, 0, 0, 0, 0, 0);
    @(posedge clk); #3;
    lv = CAN;
    reset = 1'b1;
    #1;
    chk("async_reset", 0, 0, 0, 0, 0, 0);
    @(negedge clk); reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      chk($sformatf("held_cancel_%0d", k), 0, 0, 0, 0, 0, 0);
    end
    lv = NONE;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish, want finish");
    $fatal(1);
  end

endmodule
